line_port_arbiter: RTL and testbench

- Shares the single 256-bit cache-line DFP port (feeding the burst adapter to DRAM) between the instruction cache (read-only) and the data cache (read/write).
- Sequences one whole line transaction at a time, latches the winning request, routes the response back to its owner, and enforces fairness and a turnaround cycle between transactions.
- Sits between the two L1 caches and the line-to-burst adapter.

---
 rtl/line_port_arbiter_pkg.sv | 26 ++
 rtl/line_port_arbiter_rr_pick2.sv | 25 ++
 rtl/line_port_arbiter.sv | 120 ++++++++++++
 tb/tb_line_port_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/line_port_arbiter_pkg.sv
// Shared types for the cache-line DFP port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package line_port_arbiter_pkg;

  // Requester identity; also the encoding of the picker's winner output.
  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } req_id_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } state_t;

  // 256-bit line = 32 bytes, so line addresses clear the low 5 bits.
  localparam int LINE_OFFSET_BITS = 5;

endpackage

// File: rtl/line_port_arbiter_rr_pick2.sv
// Two-way requester picker: round-robin or fixed dcache priority.
// Latency: combinational.
// Backpressure: none; winner is only meaningful when some req bit is set.
// Ports: req[0]=icache, req[1]=dcache; last = previous winner (1=dcache);
//        rr_en selects round-robin; winner 0=icache, 1=dcache.
module rr_pick2
  import line_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) begin
      // Contention: alternate away from the last winner, or favour dcache.
      winner = rr_en ? ~last : 1'b1;
    end else if (req[1]) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/line_port_arbiter.sv
// Shares one cache-line DFP port between icache (read) and dcache (read/write).
// Latency: request in IDLE -> dfp_read/dfp_write next cycle; resp same cycle as dfp_resp.
// Backpressure: requests are held by the caches until their resp; one line in flight.
// Ports: i_* icache side, d_* dcache side, dfp_* downstream burst adapter side;
//        clk, rst (synchronous, active-high).
module line_port_arbiter
  import line_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int RR_EN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] dfp_addr,
  output logic              dfp_read,
  output logic              dfp_write,
  output logic [LINE_W-1:0] dfp_wdata,
  input  logic [LINE_W-1:0] dfp_rdata,
  input  logic              dfp_resp
);

  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~((ADDR_W'(1) << LINE_OFFSET_BITS) - ADDR_W'(1));

  state_t            state_q, state_d;
  req_id_t           owner_q, last_q;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;

  logic [1:0] req;
  logic       winner;
  logic       grant;

  assign req   = {d_read | d_write, i_read};
  assign grant = (state_q == IDLE) && (req != 2'b00);

  rr_pick2 u_pick (
    .req    (req),
    .last   (last_q),
    .rr_en  (RR_EN != 0),
    .winner (winner)
  );

  // Transaction latch: everything driven downstream comes from here so the
  // port stays stable while requesters change their inputs mid-transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= ICACHE;
      last_q  <= DCACHE;
      op_q    <= READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= req_id_t'(winner);
        last_q  <= req_id_t'(winner);
        if (winner) begin
          // Read+write together is illegal; the write takes precedence.
          op_q    <= d_write ? WRITE : READ;
          addr_q  <= d_addr & LINE_MASK;
          wdata_q <= d_wdata;
        end else begin
          op_q    <= READ;
          addr_q  <= i_addr & LINE_MASK;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    dfp_read  = 1'b0;
    dfp_write = 1'b0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) state_d = BUSY;
      end
      BUSY: begin
        dfp_read  = (op_q == READ);
        dfp_write = (op_q == WRITE);
        i_resp    = dfp_resp && (owner_q == ICACHE);
        d_resp    = dfp_resp && (owner_q == DCACHE);
        if (dfp_resp) state_d = TURN;
      end
      // Mandatory gap so the just-served cache can drop its request.
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dfp_addr  = addr_q;
  assign dfp_wdata = wdata_q;
  assign i_rdata   = dfp_rdata;
  assign d_rdata   = dfp_rdata;

  a_no_rw_together : assert property (@(posedge clk) disable iff (rst)
    !(d_read && d_write))
    else $error("dcache raised read and write together");

  a_resp_only_busy : assert property (@(posedge clk) disable iff (rst)
    dfp_resp |-> (state_q == BUSY))
    else $warning("dfp_resp seen outside a transaction, ignored");

endmodule

// File: tb/tb_line_port_arbiter.sv
module tb_line_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic              i_read, d_read, d_write, dfp_resp;
  logic [LINE_W-1:0] d_wdata, dfp_rdata;

  // Instance a: round-robin. Instance b: fixed dcache priority.
  logic [LINE_W-1:0] a_i_rdata, a_d_rdata, a_dfp_wdata;
  logic [LINE_W-1:0] b_i_rdata, b_d_rdata, b_dfp_wdata;
  logic [ADDR_W-1:0] a_dfp_addr, b_dfp_addr;
  logic a_i_resp, a_d_resp, a_dfp_read, a_dfp_write;
  logic b_i_resp, b_d_resp, b_dfp_read, b_dfp_write;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  line_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .RR_EN(1)) dut_a (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(a_i_rdata), .i_resp(a_i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(a_d_rdata), .d_resp(a_d_resp),
    .dfp_addr(a_dfp_addr), .dfp_read(a_dfp_read), .dfp_write(a_dfp_write),
    .dfp_wdata(a_dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp)
  );

  line_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .RR_EN(0)) dut_b (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(b_i_rdata), .i_resp(b_i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(b_d_rdata), .d_resp(b_d_resp),
    .dfp_addr(b_dfp_addr), .dfp_read(b_dfp_read), .dfp_write(b_dfp_write),
    .dfp_wdata(b_dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp)
  );

  task automatic chk(input string tag, input logic [LINE_W-1:0] got,
                     input logic [LINE_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs change on the falling edge; checks follow #1 later.
  task automatic nxt();
    @(negedge clk);
  endtask

  logic [LINE_W-1:0] pat_a5, pat_5a, pat_c3, rdat;
  logic [ADDR_W-1:0] exp_a;

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_5a = {32{8'h5A}};
    pat_c3 = {32{8'hC3}};
    rst = 1'b1;
    i_addr = '0; d_addr = '0; i_read = 0; d_read = 0; d_write = 0;
    d_wdata = '0; dfp_resp = 0; dfp_rdata = '0;

    // Reset state
    repeat (3) nxt();
    #1;
    chk("rst_dfp_read", a_dfp_read, 0);
    chk("rst_dfp_write", a_dfp_write, 0);
    chk("rst_resp", {a_i_resp, a_d_resp, b_i_resp, b_d_resp}, 0);
    chk("rst_dfp_addr", a_dfp_addr, 0);
    rst = 1'b0;

    // Contention from reset: a alternates starting with icache, b always dcache
    i_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
    for (int t = 0; t < 6; t++) begin
      nxt(); i_read = 1; d_read = 1; #1;
      chk("cont_idle_quiet", a_dfp_read, 0);
      nxt(); #1;
      exp_a = (t % 2 == 0) ? 32'h100 : 32'h200;
      chk("cont_a_read", a_dfp_read, 1);
      chk("cont_a_addr", a_dfp_addr, exp_a);
      chk("cont_b_addr", b_dfp_addr, 32'h200);
      nxt(); rdat = {8{32'hD00D_0000 + t}}; dfp_resp = 1; dfp_rdata = rdat; #1;
      chk("cont_a_iresp", a_i_resp, (t % 2 == 0));
      chk("cont_a_dresp", a_d_resp, (t % 2 == 1));
      chk("cont_b_resp", {b_i_resp, b_d_resp}, 2'b01);
      chk("cont_rdata", a_d_rdata, rdat);
      nxt(); dfp_resp = 0;
      if (t % 2 == 0) i_read = 0; else d_read = 0;
      #1;
      chk("cont_turn_quiet", a_dfp_read, 0);
    end

    // Lone icache request is served in priority mode too
    nxt(); i_read = 1; d_read = 0; #1;
    nxt(); #1;
    chk("lone_i_b_addr", b_dfp_addr, 32'h100);
    chk("lone_i_b_read", b_dfp_read, 1);
    nxt(); dfp_resp = 1; #1;
    chk("lone_i_b_iresp", b_i_resp, 1);
    nxt(); dfp_resp = 0; i_read = 0;

    // dcache writeback; port holds latched address/data while inputs change
    nxt(); d_write = 1; d_addr = 32'h8000_0040; d_wdata = pat_a5; #1;
    chk("wr_idle_quiet", a_dfp_write, 0);
    nxt(); #1;
    chk("wr_dfp_write", a_dfp_write, 1);
    chk("wr_dfp_read", a_dfp_read, 0);
    chk("wr_addr", a_dfp_addr, 32'h8000_0040);
    chk("wr_wdata", a_dfp_wdata, pat_a5);
    d_wdata = pat_5a; d_addr = 32'hFFFF_FFFF;
    nxt(); #1;
    chk("wr_wdata_stable", a_dfp_wdata, pat_a5);
    chk("wr_addr_stable", a_dfp_addr, 32'h8000_0040);
    nxt(); dfp_resp = 1; #1;
    chk("wr_resp", {a_i_resp, a_d_resp}, 2'b01);
    nxt(); dfp_resp = 0; d_write = 0; #1;
    chk("wr_turn_quiet", a_dfp_write, 0);

    // Reset in the middle of a write discards the transaction
    nxt(); d_write = 1; d_addr = 32'h0000_0040; d_wdata = pat_c3;
    nxt(); #1;
    chk("rstmid_write", a_dfp_write, 1);
    rst = 1; d_write = 0;
    nxt(); #1;
    chk("rstmid_write_off", a_dfp_write, 0);
    chk("rstmid_addr", a_dfp_addr, 0);
    chk("rstmid_wdata", a_dfp_wdata, 0);
    chk("rstmid_resp", {a_i_resp, a_d_resp}, 0);
    rst = 0;

    // Fresh icache read after reset, response after 4 busy cycles
    nxt(); i_read = 1; i_addr = 32'h0000_1234; #1;
    chk("post_rst_idle", a_dfp_read, 0);
    nxt(); #1;
    chk("post_rst_read", a_dfp_read, 1);
    chk("post_rst_addr", a_dfp_addr, 32'h0000_1220);
    repeat (2) nxt();
    #1;
    chk("post_rst_noresp", a_i_resp, 0);
    nxt(); dfp_rdata = {8{32'hCAFE_F00D}}; dfp_resp = 1; #1;
    chk("post_rst_iresp", a_i_resp, 1);
    chk("post_rst_dresp", a_d_resp, 0);
    chk("post_rst_irdata", a_i_rdata, {8{32'hCAFE_F00D}});
    nxt(); dfp_resp = 0; i_read = 0; #1;
    chk("post_rst_pulse1", a_i_resp, 0);

    // Spurious response while idle is ignored
    nxt(); dfp_resp = 1; #1;
    chk("spur_resp", {a_i_resp, a_d_resp, b_i_resp, b_d_resp}, 0);
    chk("spur_quiet", a_dfp_read, 0);
    nxt(); dfp_resp = 0; d_read = 1; d_addr = 32'h0000_009F;
    nxt(); #1;
    chk("spur_then_read", a_dfp_read, 1);
    chk("spur_then_addr", a_dfp_addr, 32'h0000_0080);
    nxt(); dfp_resp = 1; #1;
    chk("spur_then_dresp", a_d_resp, 1);
    nxt(); dfp_resp = 0; d_read = 0;
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
